if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 12 +
 rtl/if_stage.sv | 128 ++++++++++++
 tb/tb_if_stage.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// Ports: imem_req/imem_addr (fetch -> memory), imem_valid/imem_rdata (memory -> fetch).
// Modports: master = fetch stage, slave = instruction memory.
interface if_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, 2-entry prefetch buffer, branch redirect.
// Latency: response pushed at the posedge sampling imem_valid, presented on instn one posedge later.
// Backpressure: stall holds IF_PC/instn; fetch continues until the buffer is full, then imem_req drops.
// Ports: clk, rst_n (sync, active-low), stall, beq_enable, beq_target[15:0],
//        mem (if_stage_if.master), IF_PC[15:0], instn[31:0] (32'h0 = bubble).
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        beq_enable,
  input  logic [15:0] beq_target,
  if_stage_if.master  mem,
  output logic [15:0] IF_PC,
  output logic [31:0] instn
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] data;
  } entry_t;

  state_t      state;
  logic [15:0] fetch_pc;
  entry_t      fifo_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        accept;
  logic        pop;
  logic [1:0]  count_after;
  logic [15:0] target;
  logic [15:0] reset_pc_al;

  assign target      = beq_target & 16'hFFFC;
  assign reset_pc_al = RESET_PC & 16'hFFFC;

  always_comb begin
    accept      = (state == REQ) && mem.imem_valid && !beq_enable;
    pop         = !beq_enable && !stall && (count != 2'd0);
    count_after = count + {1'b0, accept} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      fetch_pc      <= reset_pc_al;
      mem.imem_req  <= 1'b0;
      mem.imem_addr <= reset_pc_al;
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      IF_PC         <= 16'h0;
      instn         <= 32'h0;
    end else if (beq_enable) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      instn    <= 32'h0;
      fetch_pc <= target;
      mem.imem_req <= 1'b1;
      // An unanswered request is still owed a response: wait it out in DROP,
      // keeping imem_addr on the old address so the request stays stable.
      if ((state == REQ || state == DROP) && !mem.imem_valid) begin
        state <= DROP;
      end else begin
        state         <= REQ;
        mem.imem_addr <= target;
      end
    end else begin
      if (pop) begin
        IF_PC  <= fifo_mem[rd_ptr].pc;
        instn  <= fifo_mem[rd_ptr].data;
        rd_ptr <= ~rd_ptr;
      end else if (!stall) begin
        instn <= 32'h0;
      end

      if (accept) begin
        fifo_mem[wr_ptr] <= '{pc: fetch_pc, data: mem.imem_rdata};
        wr_ptr           <= ~wr_ptr;
      end
      count <= count_after;

      case (state)
        IDLE: begin
          state         <= REQ;
          mem.imem_req  <= 1'b1;
          mem.imem_addr <= fetch_pc;
        end
        REQ: begin
          if (accept) begin
            fetch_pc <= fetch_pc + 16'd4;
            if (count_after == 2'd2) begin
              state        <= HOLD;
              mem.imem_req <= 1'b0;
            end else begin
              mem.imem_addr <= fetch_pc + 16'd4;
            end
          end
        end
        HOLD: begin
          if (count_after < 2'd2) begin
            state         <= REQ;
            mem.imem_req  <= 1'b1;
            mem.imem_addr <= fetch_pc;
          end
        end
        DROP: begin
          // Owed response arrives: discard it and start fetching the target.
          if (mem.imem_valid) begin
            state         <= REQ;
            mem.imem_addr <= fetch_pc;
          end
        end
        default: begin
          state        <= IDLE;
          mem.imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized traffic against a queue-based model.
// Ports exercised: all if_stage ports on two instances (RESET_PC default and 16'hFFF8).
// Memory model answers each request after a programmable latency.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        beq_enable;
  logic [15:0] beq_target;
  logic [15:0] if_pc;
  logic [31:0] instn;
  logic [15:0] if_pc2;
  logic [31:0] instn2;

  if_stage_if ifc ();
  if_stage_if ifc2 ();

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .beq_enable(beq_enable),
    .beq_target(beq_target), .mem(ifc), .IF_PC(if_pc), .instn(instn)
  );

  if_stage #(.RESET_PC(16'hFFF8)) dut_hi (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .beq_enable(1'b0),
    .beq_target(16'h0000), .mem(ifc2), .IF_PC(if_pc2), .instn(instn2)
  );

  // Zero-wait memory for the high-reset-PC instance.
  assign ifc2.imem_valid = ifc2.imem_req;
  assign ifc2.imem_rdata = {16'h0, ifc2.imem_addr};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] data;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  ent_t        mq[$];
  logic [15:0] exp_fetch;
  logic [15:0] exp_pc;
  logic [31:0] exp_instn;
  bit          owed;
  bit          idle;

  // Memory model state
  int          lat_lo, lat_hi;
  bit          data_mode;
  bit          late_valid;
  bit          mem_busy;
  int          mem_cnt;
  logic [15:0] mem_addr;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input logic [15:0] a);
    return data_mode ? {~a, a} : {16'h0, a};
  endfunction

  task automatic mem_drive();
    ifc.imem_valid = 1'b0;
    ifc.imem_rdata = $urandom;
    if (ifc.imem_req === 1'b1) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = ifc.imem_addr;
        mem_cnt  = $urandom_range(lat_hi, lat_lo);
      end else begin
        check("addr_stable", ifc.imem_addr, mem_addr);
      end
      if (mem_cnt == 0) begin
        ifc.imem_valid = 1'b1;
        ifc.imem_rdata = mk_data(mem_addr);
        mem_busy       = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else begin
      mem_busy = 1'b0;
      if (late_valid) begin
        ifc.imem_valid = 1'b1;
        ifc.imem_rdata = 32'hDEAD_BEEF;
      end
    end
  endtask

  // One clock: drive memory, take the edge, update the model, compare.
  task automatic cycle();
    logic        rq, vl;
    logic [15:0] ad;
    logic [31:0] rd;
    ent_t        e;
    mem_drive();
    rq = ifc.imem_req;
    vl = ifc.imem_valid;
    ad = ifc.imem_addr;
    rd = ifc.imem_rdata;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mq.delete();
      exp_fetch = 16'h0000;
      exp_pc    = 16'h0;
      exp_instn = 32'h0;
      owed      = 1'b0;
      idle      = 1'b1;
    end else if (beq_enable) begin
      mq.delete();
      exp_instn = 32'h0;
      exp_fetch = beq_target & 16'hFFFC;
      owed      = (rq === 1'b1) && !vl;
      idle      = 1'b0;
    end else begin
      if (!stall) begin
        if (mq.size() > 0) begin
          e         = mq.pop_front();
          exp_pc    = e.pc;
          exp_instn = e.data;
        end else begin
          exp_instn = 32'h0;
        end
      end
      if (rq === 1'b1 && vl) begin
        if (owed) begin
          owed = 1'b0;
        end else begin
          check("fetch_addr", ad, exp_fetch);
          mq.push_back('{pc: ad, data: rd});
          exp_fetch = exp_fetch + 16'd4;
        end
      end
      idle = 1'b0;
    end
    check("if_pc", if_pc, exp_pc);
    check("instn", instn, exp_instn);
    check("imem_req", ifc.imem_req, (!idle && (owed || mq.size() < 2)));
    if (ifc.imem_req === 1'b1 && !owed) check("imem_addr", ifc.imem_addr, exp_fetch);
  endtask

  initial begin
    logic [15:0] held_pc;
    logic [31:0] held_i;
    bit          found;

    rst_n = 1'b0; stall = 1'b0; beq_enable = 1'b0; beq_target = 16'h0;
    lat_lo = 0; lat_hi = 0; data_mode = 1'b0; late_valid = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = 16'h0;
    exp_fetch = 16'h0; exp_pc = 16'h0; exp_instn = 32'h0; owed = 1'b0; idle = 1'b1;
    ifc.imem_valid = 1'b0; ifc.imem_rdata = 32'h0;

    // Reset state
    repeat (2) cycle();
    check("rst_req", ifc.imem_req, 1'b0);
    check("rst_pc", if_pc, 16'h0);
    check("rst_instn", instn, 32'h0);

    // Zero-wait streaming, plus wrap from RESET_PC=FFF8 on the second instance
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("s1_req", ifc.imem_req, 1'b1);
      check("s1_addr", ifc.imem_addr, 16'(4 * k));
      if (k >= 2) begin
        check("s1_pc", if_pc, 16'(4 * (k - 2)));
        check("s1_instn", instn, 32'(4 * (k - 2)));
        check("rpc_pc", if_pc2, 16'(32'hFFF8 + 4 * (k - 2)));
        check("rpc_instn", instn2, {16'h0, 16'(32'hFFF8 + 4 * (k - 2))});
      end
      if (k < 4) check("rpc_addr", ifc2.imem_addr, 16'(32'hFFF8 + 4 * k));
    end

    // Stall for 4 cycles mid-stream
    held_pc = if_pc;
    held_i  = instn;
    stall   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("s2_hold_pc", if_pc, held_pc);
      check("s2_hold_instn", instn, held_i);
    end
    check("s2_req_drop", ifc.imem_req, 1'b0);
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("s2_seq_pc", if_pc, 16'(32'(held_pc) + 4 * (k + 1)));
      check("s2_seq_instn", instn, {16'h0, 16'(32'(held_pc) + 4 * (k + 1))});
    end

    // Reset with a request outstanding, late response afterwards
    data_mode = 1'b1;
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (ifc.imem_req === 1'b1 && mem_busy) found = 1'b1;
      else cycle();
    end
    check("s6_found", found, 1'b1);
    rst_n = 1'b0;
    cycle();
    check("s6_req", ifc.imem_req, 1'b0);
    check("s6_pc", if_pc, 16'h0);
    check("s6_instn", instn, 32'h0);
    rst_n = 1'b1;
    late_valid = 1'b1;
    cycle();
    late_valid = 1'b0;
    check("s6_restart_req", ifc.imem_req, 1'b1);
    check("s6_restart_addr", ifc.imem_addr, 16'h0000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (instn != 32'h0) found = 1'b1;
    end
    check("s6_first_pc", if_pc, 16'h0000);
    check("s6_first_instn", instn, 32'hFFFF_0000);

    // Latency 3: redirect while the request for 0x0010 is pending
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (ifc.imem_req === 1'b1 && ifc.imem_addr == 16'h0010 && mem_busy) found = 1'b1;
      else cycle();
    end
    check("s3_found", found, 1'b1);
    beq_enable = 1'b1;
    beq_target = 16'h0040;
    cycle();
    beq_enable = 1'b0;
    check("s3_bubble", instn, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (ifc.imem_req === 1'b1 && ifc.imem_addr != 16'h0010) found = 1'b1;
    end
    check("s3_new_addr", ifc.imem_addr, 16'h0040);

    // Redirect in the same cycle as the response
    lat_lo = 0; lat_hi = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (ifc.imem_req === 1'b1 && !mem_busy) found = 1'b1;
      else cycle();
    end
    check("s4_found", found, 1'b1);
    held_pc    = if_pc;
    beq_enable = 1'b1;
    beq_target = 16'h0040;
    cycle();
    beq_enable = 1'b0;
    check("s4_pc_hold", if_pc, held_pc);
    check("s4_bubble", instn, 32'h0);
    check("s4_req", ifc.imem_req, 1'b1);
    check("s4_addr", ifc.imem_addr, 16'h0040);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      lat_lo     = 0;
      lat_hi     = 3;
      stall      = ($urandom % 4) == 0;
      beq_enable = ($urandom % 16) == 0;
      beq_target = 16'($urandom);
      rst_n      = ($urandom % 128) != 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
